// File: rtl/branch_sequencer_if.sv
// Control-unit bundle between the branch sequencer and the datapath/condition logic.
// master = sequencer side, slave = datapath/decoder side.
interface branch_sequencer_if #(
   parameter int unsigned CNT_W = 16
);
   logic             start;
   logic [1:0]       ir_c2;
   logic             con;
   logic             hold;
   logic             abort;
   logic [1:0]       cond_sel;
   logic             gra;
   logic             r_out;
   logic             con_in;
   logic             pc_out;
   logic             y_in;
   logic             c_out;
   logic             alu_add;
   logic             z_in;
   logic             zlo_out;
   logic             pc_in;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] taken_cnt;
   logic [CNT_W-1:0] nottaken_cnt;

   modport master (
      input  start, ir_c2, con, hold, abort,
      output cond_sel, gra, r_out, con_in, pc_out, y_in, c_out, alu_add,
             z_in, zlo_out, pc_in, busy, done, taken_cnt, nottaken_cnt
   );

   modport slave (
      output start, ir_c2, con, hold, abort,
      input  cond_sel, gra, r_out, con_in, pc_out, y_in, c_out, alu_add,
             z_in, zlo_out, pc_in, busy, done, taken_cnt, nottaken_cnt
   );
endinterface

// File: rtl/branch_sequencer.sv
// Sequencer for brzr/brnz/brpl/brmi: T3..T6 control steps, CON-gated PC load,
// and saturating taken / not-taken statistics counters.
module branch_sequencer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic                clk,
   input  logic                clear_n,
   branch_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T3   = 3'd1,
      S_T4   = 3'd2,
      S_T5   = 3'd3,
      S_T6   = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   logic             capture_d;
   logic             commit_d;
   logic [1:0]       cond_sel_q;
   logic [CNT_W-1:0] taken_q, nottaken_q;
   logic             gra_q, r_out_q, con_in_q, pc_out_q, y_in_q;
   logic             c_out_q, alu_add_q, z_in_q, zlo_out_q, busy_q, done_q;

   // Next state: abort beats hold, hold beats the normal step.
   always_comb begin
      state_d   = state_q;
      capture_d = 1'b0;
      if (bus.abort) begin
         state_d = S_IDLE;
      end else if (!bus.hold) begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_d   = S_T3;
                  capture_d = 1'b1;
               end
            end
            S_T3: state_d = S_T4;
            S_T4: state_d = S_T5;
            S_T5: state_d = S_T6;
            S_T6: begin
               if (bus.start) begin
                  state_d   = S_T3;
                  capture_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // A branch is committed only on the cycle T6 is actually left (not held, not aborted).
   assign commit_d = (state_q == S_T6) && !bus.hold && !bus.abort;

   // State, captured condition, counters, and strobes decoded from the next state.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q    <= S_IDLE;
         cond_sel_q <= 2'b00;
         taken_q    <= '0;
         nottaken_q <= '0;
         gra_q      <= 1'b0;
         r_out_q    <= 1'b0;
         con_in_q   <= 1'b0;
         pc_out_q   <= 1'b0;
         y_in_q     <= 1'b0;
         c_out_q    <= 1'b0;
         alu_add_q  <= 1'b0;
         z_in_q     <= 1'b0;
         zlo_out_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (capture_d) begin
            cond_sel_q <= bus.ir_c2;
         end
         if (commit_d && bus.con && (taken_q != CNT_MAX)) begin
            taken_q <= taken_q + CNT_W'(1);
         end
         if (commit_d && !bus.con && (nottaken_q != CNT_MAX)) begin
            nottaken_q <= nottaken_q + CNT_W'(1);
         end
         gra_q     <= (state_d == S_T3);
         r_out_q   <= (state_d == S_T3);
         con_in_q  <= (state_d == S_T3);
         pc_out_q  <= (state_d == S_T4);
         y_in_q    <= (state_d == S_T4);
         c_out_q   <= (state_d == S_T5);
         alu_add_q <= (state_d == S_T5);
         z_in_q    <= (state_d == S_T5);
         zlo_out_q <= (state_d == S_T6);
         done_q    <= (state_d == S_T6);
         busy_q    <= (state_d != S_IDLE);
      end
   end

   assign bus.cond_sel     = cond_sel_q;
   assign bus.gra          = gra_q;
   assign bus.r_out        = r_out_q;
   assign bus.con_in       = con_in_q;
   assign bus.pc_out       = pc_out_q;
   assign bus.y_in         = y_in_q;
   assign bus.c_out        = c_out_q;
   assign bus.alu_add      = alu_add_q;
   assign bus.z_in         = z_in_q;
   assign bus.zlo_out      = zlo_out_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.taken_cnt    = taken_q;
   assign bus.nottaken_cnt = nottaken_q;

   // CON arrives late in T6, so the PC load follows it combinationally.
   assign bus.pc_in = (state_q == S_T6) && bus.con;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer (2-bit counters to reach saturation quickly).
module tb_branch_sequencer;

   localparam int unsigned CNT_W = 2;

   // Strobe vector order: gra r_out con_in pc_out y_in c_out alu_add z_in zlo_out pc_in busy done
   localparam logic [11:0] P_IDLE = 12'b000000000000;
   localparam logic [11:0] P_T3   = 12'b111000000010;
   localparam logic [11:0] P_T4   = 12'b000110000010;
   localparam logic [11:0] P_T5   = 12'b000001110010;
   localparam logic [11:0] P_T6T  = 12'b000000001111;
   localparam logic [11:0] P_T6N  = 12'b000000001011;

   logic clk;
   logic clear_n;
   int   errors;
   int   checks;

   branch_sequencer_if #(.CNT_W(CNT_W)) bus ();

   branch_sequencer #(.CNT_W(CNT_W)) dut (
      .clk     (clk),
      .clear_n (clear_n),
      .bus     (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] strobes();
      return {bus.gra, bus.r_out, bus.con_in, bus.pc_out, bus.y_in, bus.c_out,
              bus.alu_add, bus.z_in, bus.zlo_out, bus.pc_in, bus.busy, bus.done};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one active edge, then settle so outputs are sampled away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2 clear_n = 1'b0;
      #2 clear_n = 1'b1;
      step();
   endtask

   // One complete branch with start dropped after acceptance.
   task automatic run_branch(input logic [1:0] c2, input logic cval);
      bus.ir_c2 = c2;
      bus.con   = cval;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      step();
      step();
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      clear_n   = 1'b0;
      bus.start = 1'b0;
      bus.ir_c2 = 2'b00;
      bus.con   = 1'b0;
      bus.hold  = 1'b0;
      bus.abort = 1'b0;
      #12 clear_n = 1'b1;
      step();

      chk("reset_strobes", 32'(strobes()), 32'(P_IDLE));
      chk("reset_cond_sel", 32'(bus.cond_sel), 0);

      // Async reset while in T4
      bus.ir_c2 = 2'b11;
      bus.con   = 1'b1;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      chk("pre_reset_t4", 32'(strobes()), 32'(P_T4));
      #2 clear_n = 1'b0;
      #1;
      chk("async_reset_strobes", 32'(strobes()), 32'(P_IDLE));
      chk("async_reset_cond_sel", 32'(bus.cond_sel), 0);
      chk("async_reset_taken", 32'(bus.taken_cnt), 0);
      clear_n = 1'b1;
      step();
      chk("after_reset_idle", 32'(strobes()), 32'(P_IDLE));

      // Taken branch; ir_c2 and start change mid-sequence and must be ignored
      bus.ir_c2 = 2'b01;
      bus.con   = 1'b1;
      bus.start = 1'b1;
      step();
      chk("taken_t3", 32'(strobes()), 32'(P_T3));
      chk("taken_cond_sel", 32'(bus.cond_sel), 1);
      bus.start = 1'b0;
      bus.ir_c2 = 2'b10;
      step();
      chk("taken_t4", 32'(strobes()), 32'(P_T4));
      bus.start = 1'b1;
      step();
      chk("taken_t5", 32'(strobes()), 32'(P_T5));
      bus.start = 1'b0;
      step();
      chk("taken_t6", 32'(strobes()), 32'(P_T6T));
      chk("taken_cnt_in_t6", 32'(bus.taken_cnt), 0);
      chk("cond_sel_held", 32'(bus.cond_sel), 1);
      step();
      chk("taken_idle", 32'(strobes()), 32'(P_IDLE));
      chk("taken_cnt", 32'(bus.taken_cnt), 1);

      // Not-taken branch
      do_reset();
      run_branch(2'b00, 1'b0);
      chk("nt_idle", 32'(strobes()), 32'(P_IDLE));
      chk("nt_nottaken_cnt", 32'(bus.nottaken_cnt), 1);
      chk("nt_taken_cnt", 32'(bus.taken_cnt), 0);
      chk("nt_cond_sel", 32'(bus.cond_sel), 0);
      do_reset();
      bus.ir_c2 = 2'b00;
      bus.con   = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      step();
      chk("nt_t6", 32'(strobes()), 32'(P_T6N));
      step();

      // Back-to-back: start held for 8 cycles, con 1 then 0
      do_reset();
      bus.ir_c2 = 2'b10;
      bus.con   = 1'b1;
      bus.start = 1'b1;
      step();
      chk("b2b_first_t3", 32'(strobes()), 32'(P_T3));
      step();
      step();
      step();
      chk("b2b_first_t6", 32'(strobes()), 32'(P_T6T));
      bus.ir_c2 = 2'b11;
      step();
      chk("b2b_second_t3", 32'(strobes()), 32'(P_T3));
      chk("b2b_cond_sel", 32'(bus.cond_sel), 3);
      chk("b2b_taken_mid", 32'(bus.taken_cnt), 1);
      bus.con = 1'b0;
      step();
      step();
      step();
      chk("b2b_second_t6", 32'(strobes()), 32'(P_T6N));
      bus.start = 1'b0;
      step();
      chk("b2b_idle", 32'(strobes()), 32'(P_IDLE));
      chk("b2b_taken", 32'(bus.taken_cnt), 1);
      chk("b2b_nottaken", 32'(bus.nottaken_cnt), 1);

      // Hold three cycles in T5, then one in T6
      do_reset();
      bus.ir_c2 = 2'b01;
      bus.con   = 1'b1;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      chk("hold_t5_entry", 32'(strobes()), 32'(P_T5));
      bus.hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_t5_frozen", 32'(strobes()), 32'(P_T5));
      end
      bus.hold = 1'b0;
      step();
      chk("hold_t6", 32'(strobes()), 32'(P_T6T));
      bus.hold = 1'b1;
      step();
      chk("hold_t6_frozen", 32'(strobes()), 32'(P_T6T));
      chk("hold_t6_no_count", 32'(bus.taken_cnt), 0);
      bus.hold = 1'b0;
      step();
      chk("hold_exit_idle", 32'(strobes()), 32'(P_IDLE));
      chk("hold_exit_count", 32'(bus.taken_cnt), 1);

      // Abort in T6 with con=1 (and start/hold also high)
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      step();
      bus.abort = 1'b1;
      bus.start = 1'b1;
      bus.hold  = 1'b1;
      #1;
      chk("abort_pc_in_comb", 32'(bus.pc_in), 1);
      step();
      bus.abort = 1'b0;
      bus.start = 1'b0;
      bus.hold  = 1'b0;
      chk("abort_idle", 32'(strobes()), 32'(P_IDLE));
      chk("abort_taken_unchanged", 32'(bus.taken_cnt), 1);

      // Abort from T4
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      chk("abort_t4_idle", 32'(strobes()), 32'(P_IDLE));

      // Saturation of 2-bit counters
      do_reset();
      for (int i = 0; i < 5; i++) begin
         run_branch(2'b01, 1'b1);
         if (i == 2) chk("sat_reach", 32'(bus.taken_cnt), 3);
      end
      chk("sat_hold", 32'(bus.taken_cnt), 3);
      chk("sat_nottaken", 32'(bus.nottaken_cnt), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Control sequencer for the conditional-branch instruction group (brzr, brnz, brpl, brmi). It drives the CON flag-register latch enable. It then consumes the latched condition result (CON) to decide whether the computed branch target is written to PC. The block sits in the control unit alongside the condition-evaluation logic: it produces conIn and receives conOut. It also keeps saturating taken / not-taken statistics counters for debug readout.

## Interface
- CNT_W, 16, width of each statistics counter
- clk  input  1  system clock, all state updates on rising edge
- clear_n  input  1  asynchronous, active-low reset
- start  input  1  branch instruction decoded and ready for execution; valid only with IR fields stable
- ir_c2  input  2  condition field from IR (00 zero, 01 nonzero, 10 plus, 11 minus); forwarded unchanged
- con  input  1  latched condition result from the CON flip-flop
- hold  input  1  freeze sequencer in current state (memory/bus wait)
- abort  input  1  synchronous cancel; return to IDLE
- cond_sel  output  2  condition select to condition logic (registered copy of ir_c2 captured at start)
- gra  output  1  select Ra field for register-file read
- r_out  output  1  register file drives bus
- con_in  output  1  CON flip-flop load enable
- pc_out  output  1  PC drives bus
- y_in  output  1  load Y register
- c_out  output  1  sign-extended C field drives bus
- alu_add  output  1  ALU operation = ADD
- z_in  output  1  load Z register
- zlo_out  output  1  Z low drives bus
- pc_in  output  1  load PC from bus
- busy  output  1  sequence in progress (state != IDLE)
- done  output  1  one-cycle pulse in final step
- taken_cnt  output  CNT_W  branches taken since reset
- nottaken_cnt  output  CNT_W  branches not taken since reset

## Operation
- States: IDLE, T3, T4, T5, T6; 3-bit encoding free to implementer.
- IDLE: all strobes 0. start=1 → capture ir_c2 into cond_sel, next T3.
- T3: gra=1, r_out=1, con_in=1. Next T4.
- T4: pc_out=1, y_in=1. Next T5.
- T5: c_out=1, alu_add=1, z_in=1. Next T6.
- T6: zlo_out=1, done=1, pc_in=con.
  - con=1: increment taken_cnt.
  - con=0: increment nottaken_cnt.
  - Next state is T3 if start=1 (back-to-back branch; new ir_c2 captured). Otherwise next state is IDLE.
- Strobes are Moore-decoded from state, except pc_in, which is state==T6 AND con.
- cond_sel holds its captured value until the next accepted start; it does not track ir_c2 in between.
- start while in T3–T5 is ignored (not queued).
- Counters saturate at all-ones; no wrap.

## Timing
- Reset (clear_n=0, asynchronous) drives the following, independent of clk:
  - state=IDLE
  - cond_sel=00
  - taken_cnt=0, nottaken_cnt=0
  - all strobes, busy, and done = 0
- Reset asserted mid-sequence aborts immediately; no pc_in is issued.
- Latency: start sampled high in IDLE at edge N → T3 active in cycle N+1 → pc_in/done in cycle N+4. Four busy cycles per branch.
- Back-to-back: start high during T6 → T3 in the next cycle, with no IDLE gap.
- con is sampled in T6 only. The CON flip-flop loads during T3 and holds through T6.
- hold=1: state, cond_sel and counters are frozen, and strobes keep their current-state values. In T6 this means pc_in/done stay asserted; counters increment only on the cycle T6 is exited.
- abort=1 (sync) → IDLE at the next edge from any state. It overrides hold and start.
  - abort in T6: pc_in is still asserted that cycle (combinational).
  - abort in T6: the counter is not incremented, because the branch is not committed.
- Priority at each edge: clear_n > abort > hold > normal transition.

## Test plan
- Reset: drive clear_n low mid-T4 → state IDLE, all outputs 0, counters 0 without a clock edge.
- Taken branch: start with ir_c2=01, con=1 → con_in in cycle 1, y_in in cycle 2, z_in in cycle 3; cycle 4 pc_in=1, done=1; taken_cnt=1, cond_sel=01.
- Not taken: ir_c2=00, con=0 → pc_in never asserted, done pulses in cycle 4, nottaken_cnt=1, taken_cnt=0.
- Back-to-back: start held high for 8 cycles, con alternating 1/0 per sequence → T3 directly follows T6 with no IDLE cycle; final counts taken=1, not-taken=1.
- Hold/abort: hold for 3 cycles in T5 → z_in high for 4 cycles, done 3 cycles later than unheld. abort in T6 with con=1 → next state IDLE, taken_cnt unchanged.
- Saturation: with CNT_W=2, run 5 taken branches → taken_cnt=3 and stays at 3.
